// File: rtl/image_ram_writer.sv
// Custom-instruction front end that paints a 64x64 1-bit frame RAM.
// Commands: single pixel, 32-pixel word, full-frame fill, write-count status.
module image_ram_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic [11:0] wraddress,
    output logic        wrdata,
    output logic        wren
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_PIXEL  = 2'd0;
    localparam logic [1:0] OP_WORD   = 2'd1;
    localparam logic [1:0] OP_FILL   = 2'd2;
    localparam logic [1:0] OP_STATUS = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [11:0] r_base;
    logic [31:0] r_data;
    logic [11:0] r_idx;
    logic [31:0] r_result;
    logic [31:0] r_total;

    logic [1:0]  w_op_in;
    logic        w_accept;
    logic        w_last;
    logic        w_bit;
    logic        w_unused;

    function automatic logic [31:0] cmd_len(input logic [1:0] op);
        logic [31:0] len;
        len = 32'd0;
        unique case (op)
            OP_PIXEL:  len = 32'd1;
            OP_WORD:   len = 32'd32;
            OP_FILL:   len = 32'd4096;
            OP_STATUS: len = 32'd0;
            default:   len = 32'd0;
        endcase
        return len;
    endfunction

    assign w_op_in  = dataa[31:30];
    assign w_unused = &{1'b0, dataa[29:12]};

    always_comb begin
        w_last = 1'b1;
        unique case (r_op)
            OP_PIXEL: w_last = (r_idx == 12'd0);
            OP_WORD:  w_last = (r_idx == 12'd31);
            OP_FILL:  w_last = (r_idx == 12'd4095);
            default:  w_last = 1'b1;
        endcase
    end

    // Fill replicates bit 0; other writes walk datab LSB first.
    assign w_bit = (r_op == OP_FILL) ? r_data[0] : r_data[r_idx[4:0]];

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        wren      = 1'b0;
        done      = 1'b0;
        wraddress = 12'd0;
        wrdata    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clk_en && start) begin
                    w_accept = 1'b1;
                    w_next   = (w_op_in == OP_STATUS) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                wren      = clk_en;
                wraddress = r_base + r_idx;
                wrdata    = w_bit;
                if (clk_en && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (clk_en) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= OP_PIXEL;
            r_base   <= 12'd0;
            r_data   <= 32'd0;
            r_idx    <= 12'd0;
            r_result <= 32'd0;
        end else if (clk_en) begin
            if (w_accept) begin
                r_op     <= w_op_in;
                r_base   <= (w_op_in == OP_FILL) ? 12'd0 : dataa[11:0];
                r_data   <= datab;
                r_idx    <= 12'd0;
                r_result <= (w_op_in == OP_STATUS) ? r_total
                                                   : cmd_len(w_op_in);
            end else if (r_state == S_WRITE) begin
                r_idx <= r_idx + 12'd1;
            end
        end
    end

    // Lifetime pixel-write count, pinned at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total <= 32'd0;
        end else if (wren && (r_total != 32'hFFFF_FFFF)) begin
            r_total <= r_total + 32'd1;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_image_ram_writer.sv
// Directed bench for image_ram_writer: command latency, write stream,
// stalls, busy starts, reset abort and status counting.
module tb_image_ram_writer;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic [11:0] wraddress;
    logic        wrdata;
    logic        wren;

    int n_tests;
    int n_fail;

    image_ram_writer dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .done      (done),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .wren      (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len,
                           input int busy_at,
                           output int lat, output int nwr, output int ndone,
                           output int aerr, output int derr, output int serr,
                           output logic [31:0] res);
        logic [1:0]  op;
        logic [11:0] base;
        logic [11:0] ea;
        logic [11:0] frz;
        logic        ed;
        int          st;
        op    = a[31:30];
        base  = (op == 2'd2) ? 12'd0 : a[11:0];
        lat   = -1;
        nwr   = 0;
        ndone = 0;
        aerr  = 0;
        derr  = 0;
        serr  = 0;
        res   = '0;
        st    = 0;
        frz   = '0;
        clk_en = 1'b1;
        start  = 1'b1;
        dataa  = a;
        datab  = b;
        @(posedge clk);
        for (int cyc = 1; cyc < 6000 && lat < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (!clk_en) begin
                if (wren || wraddress != frz) serr++;
            end else begin
                if (wren) begin
                    ea = (op == 2'd2) ? nwr[11:0] : base + nwr[11:0];
                    ed = (op == 2'd1) ? b[nwr[4:0]] : b[0];
                    if (wraddress != ea) aerr++;
                    if (wrdata != ed) derr++;
                    frz = wraddress;
                    nwr++;
                end
                if (done) begin
                    lat = cyc;
                    res = result;
                    ndone++;
                end
            end
            if (st > 0) begin
                st--;
                if (st == 0) clk_en = 1'b1;
            end else if (cyc == stall_at) begin
                clk_en = 1'b0;
                st     = stall_len;
            end
            if (cyc == busy_at) begin
                start = 1'b1;
                dataa = 32'hC000_0000;
            end
        end
        clk_en = 1'b1;
        @(negedge clk);
        if (done) ndone++;
        if (wren) nwr++;
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input int stall_at,
                          input int stall_len, input int busy_at,
                          input int exp_lat, input int exp_nwr,
                          input logic [31:0] exp_res);
        int lat, nwr, ndone, aerr, derr, serr;
        logic [31:0] res;
        run_cmd(a, b, stall_at, stall_len, busy_at,
                lat, nwr, ndone, aerr, derr, serr, res);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_writes"}, nwr, exp_nwr);
        chk({tag, "_done_pulses"}, ndone, 1);
        chk({tag, "_addr_errs"}, aerr, 0);
        chk({tag, "_data_errs"}, derr, 0);
        if (stall_len > 0) chk({tag, "_stall_errs"}, serr, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int bad;
        int hit;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_wren", wren, 0);
        chk("rst_result", result, 0);
        chk("rst_wraddress", wraddress, 0);
        chk("rst_wrdata", wrdata, 0);
        reset = 1'b1;

        do_cmd("pixel", 32'h0000_0041, 32'h0000_0001, -1, 0, -1, 2, 1, 1);
        do_cmd("word_wrap", 32'h4000_0FF0, 32'hA5A5_0001, -1, 0, -1,
               33, 32, 32);
        do_cmd("status_a", 32'hC000_0000, 32'h0, -1, 0, -1, 1, 0, 33);

        // start with clk_en low in IDLE must be ignored
        bad = 0;
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 32'h0000_0005;
        datab  = 32'h1;
        repeat (4) begin
            @(negedge clk);
            if (done || wren) bad++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        chk("idle_noen_ignored", bad, 0);
        do_cmd("status_b", 32'hC000_0000, 32'h0, -1, 0, -1, 1, 0, 33);

        pulse_reset();
        do_cmd("fill0", 32'h8000_0123, 32'h0, -1, 0, -1, 4097, 4096, 4096);
        do_cmd("status_fill", 32'hC000_0000, 32'h0, -1, 0, -1, 1, 0, 4096);
        do_cmd("fill_stall", 32'h8000_0000, 32'h1, 50, 10, -1,
               4107, 4096, 4096);
        do_cmd("word_busy", 32'h4000_0010, 32'h1234_5678, -1, 0, 5,
               33, 32, 32);
        do_cmd("status_c", 32'hC000_0000, 32'h0, -1, 0, -1, 1, 0, 8224);

        // abort a fill at index 100
        clk_en = 1'b1;
        start  = 1'b1;
        dataa  = 32'h8000_0000;
        datab  = 32'h1;
        @(posedge clk);
        hit = 0;
        for (int i = 0; i < 300 && hit == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (wren && wraddress == 12'd100) hit = 1;
        end
        chk("abort_reached_idx100", hit, 1);
        reset = 1'b0;
        #1;
        chk("abort_wren", wren, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || wren) bad++;
        end
        chk("abort_held", bad, 0);
        reset = 1'b1;
        do_cmd("status_post_abort", 32'hC000_0000, 32'h0, -1, 0, -1,
               1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
